// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler
//   Runs in the PWM clock domain. It reads the CPU->PWM async FIFO at a fixed
//   sample rate (stream mode), or takes values from the CPU direct duty-cycle
//   handshake (direct mode). Each new value is staged in a pending register.
//   That register is copied to the duty output only on the last cycle of a PWM
//   frame, so the PWM generator never sees a duty change mid-frame.
//
//   Optional build macro: UNDERRUN_MUTE_EN
//     defined   : an underrun loads midscale (silence) into the pending value
//     undefined : an underrun leaves the last sample in the pending value
//
// Ports
//   i_clk              PWM-domain clock
//   i_rst              synchronous, active-high reset
//   i_source_sel       0 = direct (CPU handshake), 1 = stream (FIFO)
//   i_direct_duty      CPU duty value, stable while i_direct_req is high
//   i_direct_req       CPU request level
//   o_direct_ack       one-cycle pulse, the cycle after a direct capture
//   i_fifo_data        FIFO read data, valid the cycle after o_fifo_r_en
//   i_fifo_empty       FIFO empty flag
//   o_fifo_r_en        one-cycle FIFO pop
//   o_duty             duty value for the PWM generator
//   o_frame_start      pulse on the first cycle of each PWM frame
//   o_underrun_count   saturating count of sample ticks that found the FIFO empty
module dac_sample_scheduler #(
    parameter int WIDTH         = 12,
    parameter int SAMPLE_PERIOD = 3125,
    parameter int UCNT_WIDTH    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_source_sel,
    input  logic [WIDTH-1:0]      i_direct_duty,
    input  logic                  i_direct_req,
    output logic                  o_direct_ack,
    input  logic [WIDTH-1:0]      i_fifo_data,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_r_en,
    output logic [WIDTH-1:0]      o_duty,
    output logic                  o_frame_start,
    output logic [UCNT_WIDTH-1:0] o_underrun_count
);

    localparam int TW = $clog2(SAMPLE_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [WIDTH-1:0]      r_frame_cnt;
    logic [TW-1:0]         r_stimer;
    logic                  r_src_q;
    logic [WIDTH-1:0]      r_pending;
    logic                  r_armed;
    logic [WIDTH-1:0]      r_duty;
    logic                  r_frame_start;
    logic                  r_ack;
    logic [UCNT_WIDTH-1:0] r_ucnt;

    logic w_src_chg;
    logic w_tick;
    logic w_frame_end;
    logic w_pop;
    logic w_underrun;
    logic w_capture;

    assign w_src_chg   = (i_source_sel != r_src_q);
    // A source switch restarts the sample period, so a tick never lands on
    // the switch cycle itself.
    assign w_tick      = i_source_sel && !w_src_chg && (r_stimer == TW'(SAMPLE_PERIOD - 1));
    assign w_frame_end = (r_frame_cnt == '1);

    // Next-state and per-cycle strobes. The FIFO empty flag matters only on
    // the tick cycle.
    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_underrun = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    if (!i_fifo_empty) begin
                        w_pop  = 1'b1;
                        w_next = S_READ;
                    end else begin
                        w_underrun = 1'b1;
                    end
                end else if (!i_source_sel && i_direct_req && r_armed) begin
                    w_capture = 1'b1;
                end
            end
            // The word being read is still captured. A source switch during
            // the read adds one settle cycle before the next action.
            S_READ:  w_next = w_src_chg ? S_LATCH : S_IDLE;
            S_LATCH: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_rst) begin
            w_pop      = 1'b0;
            w_underrun = 1'b0;
            w_capture  = 1'b0;
            w_next     = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        // Follows the input even during reset, so leaving reset is not seen
        // as a source switch.
        r_src_q <= i_source_sel;
        if (i_rst) begin
            r_frame_cnt   <= '0;
            r_stimer      <= '0;
            r_pending     <= '0;
            r_armed       <= 1'b1;
            r_duty        <= '0;
            r_frame_start <= 1'b0;
            r_ack         <= 1'b0;
            r_ucnt        <= '0;
        end else begin
            r_frame_cnt   <= r_frame_cnt + 1'b1;
            r_frame_start <= w_frame_end;
            if (w_frame_end) begin
                r_duty <= r_pending;
            end

            if (!i_source_sel || w_src_chg || (r_stimer == TW'(SAMPLE_PERIOD - 1))) begin
                r_stimer <= '0;
            end else begin
                r_stimer <= r_stimer + 1'b1;
            end

            if (r_state == S_READ) begin
                r_pending <= i_fifo_data;
            end else if (w_capture) begin
                r_pending <= i_direct_duty;
            end
`ifdef UNDERRUN_MUTE_EN
            else if (w_underrun) begin
                r_pending <= {1'b1, {(WIDTH-1){1'b0}}};
            end
`endif

            if (w_underrun && (r_ucnt != '1)) begin
                r_ucnt <= r_ucnt + 1'b1;
            end

            // Re-arm only after the request has been seen low, so a request
            // held high is captured once.
            if (!i_direct_req) begin
                r_armed <= 1'b1;
            end else if (w_capture) begin
                r_armed <= 1'b0;
            end
            r_ack <= w_capture;
        end
    end

    assign o_fifo_r_en      = w_pop;
    assign o_direct_ack     = r_ack;
    assign o_duty           = r_duty;
    assign o_frame_start    = r_frame_start;
    assign o_underrun_count = r_ucnt;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
module tb_dac_sample_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       source_sel;
    logic [3:0] direct_duty;
    logic       direct_req;
    logic       direct_ack;
    logic [3:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_r_en;
    logic [3:0] duty;
    logic       frame_start;
    logic [1:0] underrun_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int idx   = 0;
    int n_en  = 0;
    int n_ack = 0;
    logic prev_en = 1'b0;
    logic [3:0] words [4] = '{4'd3, 4'd7, 4'd11, 4'd13};

    always #5 clk = ~clk;

    dac_sample_scheduler #(.WIDTH(4), .SAMPLE_PERIOD(20), .UCNT_WIDTH(2)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_source_sel     (source_sel),
        .i_direct_duty    (direct_duty),
        .i_direct_req     (direct_req),
        .o_direct_ack     (direct_ack),
        .i_fifo_data      (fifo_data),
        .i_fifo_empty     (fifo_empty),
        .o_fifo_r_en      (fifo_r_en),
        .o_duty           (duty),
        .o_frame_start    (frame_start),
        .o_underrun_count (underrun_count)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", tag, cyc, got, exp);
        end
    endtask

    // One clock; outputs are observed 1 ns after the edge. The FIFO model
    // presents the next word from the second cycle after a pop.
    task automatic step();
        logic en;
        en = fifo_r_en;
        @(posedge clk);
        #1;
        cyc++;
        if (prev_en && idx < 3) idx++;
        prev_en   = en;
        fifo_data = words[idx];
        if (fifo_r_en)  n_en++;
        if (direct_ack) n_ack++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset(input logic sel, input logic req, input logic [3:0] dd, input logic emp);
        rst         = 1'b1;
        source_sel  = sel;
        direct_req  = req;
        direct_duty = dd;
        fifo_empty  = emp;
        idx         = 0;
        prev_en     = 1'b0;
        fifo_data   = words[0];
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        cyc   = 0;
        n_en  = 0;
        n_ack = 0;
    endtask

    initial begin
        // ---- reset state + stream basic
        rst = 1'b1; source_sel = 1'b1; direct_req = 1'b0; direct_duty = 4'd0;
        fifo_empty = 1'b0; fifo_data = words[0];
        repeat (3) @(posedge clk);
        #1;
        chk("rst_duty", duty, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_en", fifo_r_en, 0);
        chk("rst_ack", direct_ack, 0);
        chk("rst_ucnt", underrun_count, 0);
        do_reset(1'b1, 1'b0, 4'd0, 1'b0);
        run_to(18); chk("s_en18", fifo_r_en, 0);
        run_to(19); chk("s_en19", fifo_r_en, 1);
        run_to(20); chk("s_en20", fifo_r_en, 0);
        run_to(16); 
        run_to(31); chk("s_duty31", duty, 0);
        run_to(32); chk("s_duty32", duty, 3); chk("s_fs32", frame_start, 1);
        run_to(33); chk("s_fs33", frame_start, 0);
        run_to(39); chk("s_en39", fifo_r_en, 1);
        run_to(47); chk("s_duty47", duty, 3);
        run_to(48); chk("s_duty48", duty, 7);
        run_to(59); chk("s_en59", fifo_r_en, 1);
        run_to(63); chk("s_duty63", duty, 7);
        run_to(64); chk("s_duty64", duty, 11);
        chk("s_npop", n_en, 3);
        chk("s_ucnt", underrun_count, 0);

        // ---- underrun from the second tick on, 2-bit counter saturates
        do_reset(1'b1, 1'b0, 4'd0, 1'b0);
        run_to(19); chk("u_en19", fifo_r_en, 1);
        run_to(20); fifo_empty = 1'b1;
        run_to(39); chk("u_en39", fifo_r_en, 0); chk("u_cnt39", underrun_count, 0);
        run_to(40); chk("u_cnt40", underrun_count, 1);
        run_to(32); 
        run_to(47);
        run_to(48);
`ifdef UNDERRUN_MUTE_EN
        chk("u_duty48", duty, 8);
`else
        chk("u_duty48", duty, 3);
`endif
        run_to(60); chk("u_cnt60", underrun_count, 2);
        run_to(80); chk("u_cnt80", underrun_count, 3);
        run_to(100); chk("u_sat100", underrun_count, 3);
        chk("u_npop", n_en, 1);

        // ---- direct handshake
        do_reset(1'b0, 1'b1, 4'd5, 1'b0);
        run_to(1); chk("d_ack1", direct_ack, 1);
        run_to(15); chk("d_duty15", duty, 0);
        run_to(16); chk("d_duty16", duty, 5);
        run_to(40); chk("d_nack", n_ack, 1); chk("d_nen", n_en, 0);
        direct_req = 1'b0;
        run_to(41); direct_req = 1'b1; direct_duty = 4'd9; n_ack = 0;
        run_to(42); chk("d_ack42", direct_ack, 1);
        run_to(47); chk("d_duty47", duty, 5);
        run_to(48); chk("d_duty48", duty, 9);
        run_to(60); chk("d_nack2", n_ack, 1);

        // ---- source switch
        do_reset(1'b1, 1'b0, 4'd0, 1'b0);
        run_to(30); chk("w_npop30", n_en, 1);
        source_sel = 1'b0; n_en = 0;
        run_to(80); chk("w_nen_dir", n_en, 0);
        source_sel = 1'b1; n_en = 0;
        run_to(99); chk("w_en99", fifo_r_en, 0); chk("w_nen_wait", n_en, 0);
        run_to(100); chk("w_en100", fifo_r_en, 1);

        // ---- frame alignment: pending changes at counter 7
        do_reset(1'b0, 1'b0, 4'd0, 1'b0);
        run_to(7); direct_req = 1'b1; direct_duty = 4'd6;
        for (int i = 8; i <= 15; i++) begin
            run_to(i);
            chk("f_duty_hold", duty, 0);
            chk("f_fs_low", frame_start, 0);
        end
        run_to(16); chk("f_duty16", duty, 6); chk("f_fs16", frame_start, 1);
        run_to(17); direct_req = 1'b0;
        run_to(23); direct_req = 1'b1; direct_duty = 4'd2;
        run_to(24); chk("f_fs24", frame_start, 0);
        run_to(31); chk("f_duty31", duty, 6);
        run_to(32); chk("f_duty32", duty, 2); chk("f_fs32", frame_start, 1);
        direct_req = 1'b0;

        // ---- reset during READ
        do_reset(1'b1, 1'b0, 4'd0, 1'b0);
        run_to(32); chk("r_duty32", duty, 3);
        run_to(39); chk("r_en39", fifo_r_en, 1);
        run_to(40);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("r_duty", duty, 0);
        chk("r_fs", frame_start, 0);
        chk("r_en", fifo_r_en, 0);
        chk("r_ack", direct_ack, 0);
        chk("r_ucnt", underrun_count, 0);
        do_reset(1'b1, 1'b0, 4'd0, 1'b1);
        run_to(16); chk("r_pend0", duty, 0); chk("r_fs16", frame_start, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
